coax_tx_scheduler: RTL and testbench

- Frame-level scheduler in front of the buffered coax transmitter (FIFO plus serializer).
- Two requesters offer 10-bit word streams with a frame-end marker. The scheduler grants one whole frame at a time, round-robin, and loads its words into the transmit FIFO. It then fires the start strobe and supervises transmission until the line is idle.
- After each frame it enforces an inter-frame gap and reports per-frame completion or error.

---
 rtl/coax_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_coax_tx_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_tx_scheduler.sv
// Frame-level round-robin scheduler feeding the buffered coax transmitter.
// Loads one whole frame into the FIFO, starts it, supervises the line, then holds an inter-frame gap.
module coax_tx_scheduler #(
  parameter int GAP_CLOCKS    = 16,
  parameter int START_TIMEOUT = 64,
  parameter int TIMER_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [19:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [9:0]  tx_data,
  output logic        tx_load_strobe,
  output logic        tx_start_strobe,
  input  logic        tx_empty,
  input  logic        tx_full,
  input  logic        tx_active,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        frame_done,
  output logic        frame_error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    START,
    WAIT_ACTIVE,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] GAP_LOAD   = TIMER_WIDTH'(GAP_CLOCKS);
  localparam logic [TIMER_WIDTH-1:0] START_LOAD = TIMER_WIDTH'(START_TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] ONE        = TIMER_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [1:0]             grant_nxt;
  logic                   ptr, ptr_nxt;
  logic [TIMER_WIDTH-1:0] timer, timer_nxt;
  logic                   err, err_nxt;
  logic [1:0]             cand;
  logic                   win;
  logic                   own;
  logic                   own_valid;
  logic                   own_last;

  assign own       = grant[1];
  assign own_valid = req_valid[own];
  assign own_last  = req_last[own];
  assign tx_data   = own ? req_data[19:10] : req_data[9:0];
  assign busy      = (state != IDLE);
  assign cand      = req_valid & {2{tx_empty}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 2'b00;
      ptr   <= 1'b0;
      timer <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
      timer <= timer_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    ptr_nxt         = ptr;
    timer_nxt       = timer;
    err_nxt         = err;
    win             = 1'b0;
    req_ready       = 2'b00;
    tx_load_strobe  = 1'b0;
    tx_start_strobe = 1'b0;
    frame_done      = 1'b0;
    frame_error     = 1'b0;

    case (state)
      IDLE: begin
        if (cand != 2'b00) begin
          win       = (cand == 2'b11) ? ptr : cand[1];
          grant_nxt = win ? 2'b10 : 2'b01;
          ptr_nxt   = ~win;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        req_ready[own] = ~tx_full;
        tx_load_strobe = own_valid & ~tx_full;
        if (own_valid) begin
          // a full FIFO wins over a coinciding last marker: the word is refused
          if (tx_full) begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end else if (own_last) begin
            state_nxt = START;
          end
        end
      end

      DRAIN: begin
        req_ready[own] = 1'b1;
        if (own_valid && own_last) state_nxt = START;
      end

      START: begin
        tx_start_strobe = 1'b1;
        timer_nxt       = START_LOAD;
        state_nxt       = WAIT_ACTIVE;
      end

      WAIT_ACTIVE: begin
        if (tx_active) begin
          state_nxt = WAIT_DONE;
        end else if (timer <= ONE) begin
          timer_nxt = '0;
          err_nxt   = 1'b1;
          state_nxt = WAIT_DONE;
        end else begin
          timer_nxt = timer - ONE;
        end
      end

      WAIT_DONE: begin
        if (!tx_active && tx_empty) begin
          frame_error = err;
          frame_done  = ~err;
          err_nxt     = 1'b0;
          if (GAP_CLOCKS == 0) begin
            grant_nxt = 2'b00;
            state_nxt = IDLE;
          end else begin
            timer_nxt = GAP_LOAD;
            state_nxt = GAP;
          end
        end
      end

      GAP: begin
        if (timer <= ONE) begin
          timer_nxt = '0;
          grant_nxt = 2'b00;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - ONE;
        end
      end

      default: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coax_tx_scheduler.sv
// Directed bench for coax_tx_scheduler: frame-level reference model checked every clock,
// a small transmitter emulation, and literal expectations for each scenario.
module tb_coax_tx_scheduler;
  localparam int GAP = 16;
  localparam int TMO = 64;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [9:0]  d0 = '0, d1 = '0;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [19:0] req_data;
  logic [9:0]  tx_data;
  logic        tx_load_strobe, tx_start_strobe, busy, frame_done, frame_error;
  logic        tx_empty = 1'b1, tx_full = 1'b0, tx_active = 1'b0;

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};

  always #5 clk = ~clk;

  coax_tx_scheduler #(.GAP_CLOCKS(GAP), .START_TIMEOUT(TMO), .TIMER_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_load_strobe(tx_load_strobe), .tx_start_strobe(tx_start_strobe),
    .tx_empty(tx_empty), .tx_full(tx_full), .tx_active(tx_active),
    .busy(busy), .grant(grant), .frame_done(frame_done), .frame_error(frame_error)
  );

  // Transmitter emulation: counts loads, goes active a while after start, then empties.
  int fifo_cnt = 0, full_at = 8, act_delay = 2, act_len = 5, cd = -1, al = 0;
  bit dead_line = 1'b0;
  logic ld_s, st_s;
  always begin
    @(negedge clk);
    ld_s = tx_load_strobe;
    st_s = tx_start_strobe;
    @(posedge clk);
    #1;
    if (reset) begin
      fifo_cnt = 0; cd = -1; al = 0; tx_active = 1'b0;
    end else begin
      if (ld_s) fifo_cnt++;
      if (al > 0) begin
        al--;
        if (al == 0) begin tx_active = 1'b0; fifo_cnt = 0; end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin tx_active = 1'b1; al = act_len; cd = -1; end
      end
      if (st_s) begin
        if (dead_line) fifo_cnt = 0;
        else cd = act_delay;
      end
    end
    tx_empty = (fifo_cnt == 0);
    tx_full  = (fifo_cnt >= full_at);
  end

  // Reference model: who owns the line and which phase of the frame life it is in.
  int m_owner = -1, m_ptr = 0, m_watch_clk = 0, m_gap_left = 0;
  bit m_fill = 0, m_drop = 0, m_kick = 0, m_watch = 0, m_finish = 0, m_bad = 0;
  always @(posedge clk or posedge reset) begin : model
    int w;
    logic [1:0] c;
    if (reset) begin
      m_owner <= -1; m_ptr <= 0; m_fill <= 0; m_drop <= 0; m_kick <= 0;
      m_watch <= 0; m_finish <= 0; m_bad <= 0; m_watch_clk <= 0; m_gap_left <= 0;
    end else if (m_owner < 0) begin
      c = req_valid & {tx_empty, tx_empty};
      if (c != 2'b00) begin
        w = (c == 2'b11) ? m_ptr : (c[1] ? 1 : 0);
        m_owner <= w;
        m_ptr   <= 1 - w;
        m_fill  <= 1;
      end
    end else if (m_fill) begin
      if (req_valid[m_owner] && tx_full) begin
        m_fill <= 0; m_drop <= 1; m_bad <= 1;
      end else if (req_valid[m_owner] && req_last[m_owner]) begin
        m_fill <= 0; m_kick <= 1;
      end
    end else if (m_drop) begin
      if (req_valid[m_owner] && req_last[m_owner]) begin m_drop <= 0; m_kick <= 1; end
    end else if (m_kick) begin
      m_kick <= 0; m_watch <= 1; m_watch_clk <= 0;
    end else if (m_watch) begin
      if (tx_active) begin
        m_watch <= 0; m_finish <= 1;
      end else if (m_watch_clk + 1 >= TMO) begin
        m_watch <= 0; m_finish <= 1; m_bad <= 1;
      end else begin
        m_watch_clk <= m_watch_clk + 1;
      end
    end else if (m_finish) begin
      if (!tx_active && tx_empty) begin
        m_finish <= 0; m_bad <= 0;
        if (GAP == 0) m_owner <= -1;
        else m_gap_left <= GAP;
      end
    end else begin
      if (m_gap_left <= 1) begin m_gap_left <= 0; m_owner <= -1; end
      else m_gap_left <= m_gap_left - 1;
    end
  end

  int n_checks = 0, n_errors = 0;
  int cyc = 0, st_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_st_cyc = 0, last_done_cyc = 0, last_err_cyc = 0, last_busy_cyc = 0;
  logic [9:0] ld_words[$];
  int         ld_cyc[$];
  logic [1:0] gnt_log[$];
  logic [1:0] prev_grant = 2'b00;
  int         g;
  logic [1:0] e_ready, e_grant;
  logic       e_ld, e_fin;
  int         d_base, e_base, s_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int probe(input int which);
    case (which)
      0:       return done_cnt;
      1:       return err_cnt;
      2:       return gnt_log.size();
      3:       return int'(tx_active);
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int limit, input string name);
    int k = 0;
    while (probe(which) < target && k < limit) begin
      @(posedge clk); #1; k++;
    end
    if (probe(which) < target) begin
      n_checks++; n_errors++;
      $display("FAIL %s: wait expired after %0d clocks, got %0d required %0d", name, limit, probe(which), target);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int n, input logic [9:0] base);
    int k = 0, t = 0;
    logic hs;
    while (k < n && t < 300) begin
      if (r == 0) begin v0 = 1; d0 = base + 10'(k); l0 = (k == n - 1); end
      else        begin v1 = 1; d1 = base + 10'(k); l1 = (k == n - 1); end
      @(negedge clk);
      hs = req_ready[r];
      @(posedge clk); #1;
      t++;
      if (hs) k++;
    end
    if (r == 0) begin v0 = 0; l0 = 0; end else begin v1 = 0; l1 = 0; end
    if (k < n) begin
      n_checks++; n_errors++;
      $display("FAIL send_r%0d: only %0d of %0d words accepted", r, k, n);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          cyc++;
          g       = m_owner;
          e_grant = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
          e_ready = 2'b00;
          e_ld    = 1'b0;
          if (g >= 0 && m_fill) begin
            e_ready[g] = !tx_full;
            e_ld       = req_valid[g] && !tx_full;
          end
          if (g >= 0 && m_drop) e_ready[g] = 1'b1;
          e_fin = m_finish && !tx_active && tx_empty;
          chk("busy", busy, g >= 0);
          chk("grant", grant, e_grant);
          chk("req_ready", req_ready, e_ready);
          chk("tx_load_strobe", tx_load_strobe, e_ld);
          if (e_ld) chk("tx_data", tx_data, (g == 0) ? d0 : d1);
          chk("tx_start_strobe", tx_start_strobe, m_kick);
          chk("frame_done", frame_done, e_fin && !m_bad);
          chk("frame_error", frame_error, e_fin && m_bad);
          if (tx_load_strobe) begin ld_words.push_back(tx_data); ld_cyc.push_back(cyc); end
          if (tx_start_strobe) begin st_cnt++; last_st_cyc = cyc; end
          if (frame_done) begin done_cnt++; last_done_cyc = cyc; end
          if (frame_error) begin err_cnt++; last_err_cyc = cyc; end
          if (busy) last_busy_cyc = cyc;
          if (grant != 2'b00 && prev_grant == 2'b00) gnt_log.push_back(grant);
          prev_grant = grant;
        end else begin
          prev_grant = 2'b00;
        end
      end
    join_none

    // reset with requester 0 already waiting
    v0 = 1; d0 = 10'h155; l0 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, grant, req_ready, tx_load_strobe, tx_start_strobe, frame_done, frame_error}, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    chk("first_grant", grant, 2'b01);
    chk("first_load_strobe", tx_load_strobe, 1);
    chk("first_tx_data", tx_data, 10'h155);
    @(posedge clk); #1;
    v0 = 0; l0 = 0;
    wait_for(0, 1, 100, "first_frame_done");
    clocks(GAP + 4);

    // three-word frame, 40 active clocks, then gap
    ld_words.delete(); ld_cyc.delete();
    act_len = 40;
    d_base = done_cnt; e_base = err_cnt;
    send(0, 3, 10'h101);
    wait_for(0, d_base + 1, 200, "three_word_done");
    clocks(GAP + 8);
    chk("three_word_loads", ld_words.size(), 3);
    chk("word0", ld_words[0], 10'h101);
    chk("word1", ld_words[1], 10'h102);
    chk("word2", ld_words[2], 10'h103);
    chk("loads_consecutive", ld_cyc[2] - ld_cyc[0], 2);
    chk("start_after_last_load", last_st_cyc, ld_cyc[2] + 1);
    chk("three_word_done_count", done_cnt - d_base, 1);
    chk("three_word_err_count", err_cnt - e_base, 0);
    chk("gap_busy_clocks", last_busy_cyc - last_done_cyc, GAP);

    // reset while the frame is on the line
    act_len = 50;
    d_base = done_cnt; e_base = err_cnt;
    send(0, 1, 10'h2A5);
    wait_for(3, 1, 50, "line_active");
    clocks(3);
    #2;
    reset = 1;
    #1;
    chk("async_reset_grant_busy", {grant, busy}, 0);
    chk("async_reset_pulses", {frame_done, frame_error}, 0);
    clocks(2);
    reset = 0;
    clocks(3);
    chk("no_pulse_after_reset", (done_cnt - d_base) + (err_cnt - e_base), 0);

    // both requesters always valid with single-word frames
    gnt_log.delete();
    act_delay = 1; act_len = 3;
    d_base = done_cnt;
    d0 = 10'h0A0; d1 = 10'h0B0; l0 = 1; l1 = 1; v0 = 1; v1 = 1;
    wait_for(2, 4, 400, "four_grants");
    v0 = 0; v1 = 0; l0 = 0; l1 = 0;
    wait_for(0, d_base + 4, 200, "four_frames_done");
    chk("rr_grant0", gnt_log[0], 2'b01);
    chk("rr_grant1", gnt_log[1], 2'b10);
    chk("rr_grant2", gnt_log[2], 2'b01);
    chk("rr_grant3", gnt_log[3], 2'b10);
    clocks(GAP + 4);

    // FIFO fills after two words of a five-word frame
    ld_words.delete(); ld_cyc.delete();
    full_at = 2; act_delay = 2; act_len = 10;
    d_base = done_cnt; e_base = err_cnt; s_base = st_cnt;
    send(0, 5, 10'h200);
    wait_for(1, e_base + 1, 200, "overflow_error");
    clocks(GAP + 4);
    full_at = 8;
    chk("overflow_loads", ld_words.size(), 2);
    chk("overflow_word1", ld_words[1], 10'h201);
    chk("overflow_starts", st_cnt - s_base, 1);
    chk("overflow_err_count", err_cnt - e_base, 1);
    chk("overflow_done_count", done_cnt - d_base, 0);

    // line never goes active; next request waits out the gap and is still served
    dead_line = 1;
    d_base = done_cnt; e_base = err_cnt;
    send(1, 1, 10'h3C3);
    wait_for(1, e_base + 1, 200, "timeout_error");
    dead_line = 0;
    chk("timeout_latency", last_err_cyc - last_st_cyc, TMO + 1);
    chk("timeout_done_count", done_cnt - d_base, 0);
    send(0, 1, 10'h044);
    wait_for(0, d_base + 1, 200, "after_timeout_done");
    chk("after_timeout_grant", gnt_log[gnt_log.size() - 1], 2'b01);
    chk("after_timeout_word", ld_words[ld_words.size() - 1], 10'h044);
    clocks(GAP + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
